// File: rtl/mux_pkg.sv
// Shared constants for the 8-way round-robin collector: word/channel/select widths and FSM encoding.
package mux_pkg;
  localparam int WIDTH = 16;
  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;
endpackage

// File: rtl/Mux8Way16.sv
// 16-bit 8-way combinational selector; zero latency, no flow control.
module Mux8Way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  input  logic [2:0]  sel,
  output logic [15:0] out
);
  always_comb begin
    case (sel)
      3'd0:    out = a;
      3'd1:    out = b;
      3'd2:    out = c;
      3'd3:    out = d;
      3'd4:    out = e;
      3'd5:    out = f;
      3'd6:    out = g;
      default: out = h;
    endcase
  end
endmodule

// File: rtl/rr_arbiter8.sv
// Combinational 8-way round-robin arbiter: first request at or after ptr wins, wrapping 7->0.
// gnt is gated by en; gnt_idx/any report the winner regardless of en.
module rr_arbiter8
  import mux_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [NCH-1:0]   gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);
  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    // 3-bit index arithmetic provides the modulo-8 wrap for free
    for (int i = 0; i < NCH; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    any = found;
    if (en && found) gnt[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/mux8way_rr_collector.sv
// Merges 8 valid/ready channels into one registered, source-tagged stream; 1-cycle latency, full throughput.
// Output stalls (out_valid && !out_ready) freeze the register and withhold every in_ready.
module mux8way_rr_collector
  import mux_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);
  logic [0:0]       state;
  logic [SEL_W-1:0] ptr;
  logic             load;
  logic [NCH-1:0]   gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             any;
  logic [WIDTH-1:0] sel_data;

  assign load = (state == ST_EMPTY) || out_ready;

  rr_arbiter8 u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .en      (load && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  Mux8Way16 u_mux (
    .a   (in_data[0*WIDTH +: WIDTH]),
    .b   (in_data[1*WIDTH +: WIDTH]),
    .c   (in_data[2*WIDTH +: WIDTH]),
    .d   (in_data[3*WIDTH +: WIDTH]),
    .e   (in_data[4*WIDTH +: WIDTH]),
    .f   (in_data[5*WIDTH +: WIDTH]),
    .g   (in_data[6*WIDTH +: WIDTH]),
    .h   (in_data[7*WIDTH +: WIDTH]),
    .sel (gnt_idx),
    .out (sel_data)
  );

  assign in_ready  = gnt;
  assign out_valid = (state == ST_FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      ptr      <= '0;
      out_data <= '0;
      out_sel  <= '0;
    end else if (load) begin
      if (any) begin
        state    <= ST_FULL;
        out_data <= sel_data;
        out_sel  <= gnt_idx;
        ptr      <= gnt_idx + SEL_W'(1);
      end else begin
        state <= ST_EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_mux8way_rr_collector.sv
// Randomized + directed bench for mux8way_rr_collector with a queue scoreboard and a rule-level model.
module tb_mux8way_rr_collector;
  import mux_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_sel;
  logic                 out_ready;

  int errors = 0;
  int checks = 0;

  mux8way_rr_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: observable behaviour only
  logic [WIDTH-1:0] dat [NCH];
  int               m_ptr = 0;
  bit               m_full = 0;
  logic [WIDTH-1:0] m_data = '0;
  int               m_sel = 0;
  logic [WIDTH+SEL_W-1:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check the cycle at negedge, then advance the model past the next edge.
  task automatic step(input logic r, input logic [NCH-1:0] v, input logic rdy);
    int g;
    logic [NCH-1:0] exp_rdy;
    @(posedge clk);
    #1;
    rst_n     = r;
    in_valid  = v;
    out_ready = rdy;
    for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = dat[i];
    @(negedge clk);
    g = -1;
    if (r && (!m_full || rdy)) begin
      for (int k = 0; k < NCH; k++) begin
        if (g < 0 && v[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
    if (!r) begin
      m_full = 0; m_ptr = 0; m_data = '0; m_sel = 0;
      sb.delete();
    end else if (!m_full || rdy) begin
      if (g >= 0) begin
        sb.push_back({dat[g], SEL_W'(g)});
        m_full = 1; m_data = dat[g]; m_sel = g; m_ptr = (g + 1) % NCH;
      end else begin
        m_full = 0;
      end
    end
  endtask

  // Monitor: every accepted output word must match the oldest granted word
  logic [WIDTH+SEL_W-1:0] head;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: output word %0h/%0d with nothing expected", out_data, out_sel);
      end else begin
        head = sb.pop_front();
        if ({out_data, out_sel} !== head) begin
          errors++;
          $display("FAIL sb_word: got data=%0h sel=%0d expected data=%0h sel=%0d",
                   out_data, out_sel, head[WIDTH+SEL_W-1:SEL_W], head[SEL_W-1:0]);
        end
      end
    end
  end

  task automatic set_seq_data();
    for (int i = 0; i < NCH; i++) dat[i] = WIDTH'(16'h1000 + i);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; in_data = '0;
    set_seq_data();
    @(posedge clk);

    // Reset with all channels requesting, then first grant goes to channel 0
    step(0, 8'hFF, 1);
    step(0, 8'hFF, 1);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    step(1, 8'hFF, 1);
    chk("first_grant", 32'(in_ready), 32'h01);

    // Single channel
    step(0, 8'h00, 1);
    dat[5] = 16'hBEEF;
    step(1, 8'h20, 1);
    chk("single_rdy", 32'(in_ready), 32'h20);
    step(1, 8'h00, 1);
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data", 32'(out_data), 32'hBEEF);
    chk("single_sel", 32'(out_sel), 32'd5);

    // Round-robin wrap over 10 grants
    set_seq_data();
    step(0, 8'h00, 1);
    for (int k = 0; k < 11; k++) begin
      step(1, (k < 10) ? 8'hFF : 8'h00, 1);
      if (k >= 1) begin
        chk("rr_sel", 32'(out_sel), 32'((k - 1) % 8));
        chk("rr_data", 32'(out_data), 32'(16'h1000 + (k - 1) % 8));
      end
    end

    // Backpressure holding channel 2
    step(0, 8'h00, 1);
    for (int k = 0; k < 3; k++) step(1, 8'hFF, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 8'hFF, 0);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_sel", 32'(out_sel), 32'd2);
      chk("bp_data", 32'(out_data), 32'h1002);
    end
    step(1, 8'hFF, 1);
    chk("bp_next_rdy", 32'(in_ready), 32'h08);
    step(1, 8'h00, 1);
    chk("bp_next_sel", 32'(out_sel), 32'd3);

    // Sparse wrap from ptr=6
    step(0, 8'h00, 1);
    step(1, 8'h20, 1);
    step(1, 8'h03, 1);
    chk("sparse_g0", 32'(in_ready), 32'h01);
    step(1, 8'h03, 1);
    chk("sparse_g1", 32'(in_ready), 32'h02);
    step(1, 8'h00, 1);
    chk("sparse_sel", 32'(out_sel), 32'd1);
    step(1, 8'h00, 1);
    chk("sparse_drop", 32'(out_valid), 32'h0);

    // Mid-operation reset while FULL
    step(1, 8'hF0, 1);
    step(1, 8'hFF, 0);
    step(0, 8'hFF, 1);
    chk("midrst_rdy", 32'(in_ready), 32'h0);
    step(1, 8'h00, 1);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    step(1, 8'hFF, 1);
    chk("midrst_ptr0", 32'(in_ready), 32'h01);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [NCH-1:0] v;
      for (int i = 0; i < NCH; i++) dat[i] = WIDTH'($urandom);
      v = NCH'($urandom) & NCH'($urandom);
      if ($urandom_range(0, 9) == 0) v = 8'hFF;
      step(($urandom_range(0, 99) != 0), v, ($urandom_range(0, 9) < 7));
    end
    for (int n = 0; n < 4; n++) step(1, 8'h00, 1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux8way_rr_collector.md
Name: mux8way_rr_collector

Overview:
- Sequential counterpart of the 8-way demultiplexer: merges eight independent valid/ready input channels onto one registered output stream.
- Each output word is tagged with the 3-bit select index of its source channel.
- Channel choice is round-robin, so no requesting channel starves.
- Sits upstream of any single-port consumer, e.g. a memory write port or a serial transmitter, fed by per-channel producers.

Parameters:
- WIDTH, 16, data word width in bits (Hack word).
- NCH, 8, number of input channels; fixed at 8, other values unsupported.
- SEL_W, 3, select/index width; must equal log2(NCH).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, NCH, per-channel request; bit i = channel i has a word.
- in_data, input, NCH*WIDTH, channel i data on bits [i*WIDTH +: WIDTH].
- in_ready, output, NCH, one-hot or zero; bit i = channel i word consumed this cycle.
- out_valid, output, 1, output register holds a word.
- out_data, output, WIDTH, registered data word.
- out_sel, output, SEL_W, index of the channel that supplied out_data.
- out_ready, input, 1, consumer accepts the word when out_valid && out_ready.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0, state=EMPTY.
  - in_ready=0 in every cycle where rst_n=0.
  - Reset mid-transfer discards the held word; no handshake completes in that cycle.
- State machine, two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Load enable: load = (state==EMPTY) || out_ready. This makes the block a full-throughput pipe register.
- Arbitration (combinational, in the same cycle):
  - Among bits of in_valid, grant the first set bit found scanning ptr, ptr+1, ... ptr+7, modulo 8 (wrap 7->0).
  - No bits set: no grant.
- in_ready = onehot(grant) when load && any in_valid; otherwise 0.
  - in_ready never depends on in_data.
  - in_ready[i] is never asserted with in_valid[i]=0.
- On a grant, next edge:
  - out_data <= data of granted channel.
  - out_sel <= grant index.
  - out_valid <= 1.
  - ptr <= grant index + 1 (mod 8).
- No grant and load: out_valid <= 0; out_data and out_sel hold their last values; ptr holds.
- Hold: out_valid && !out_ready means out_data, out_sel and out_valid remain stable and ptr holds.
- Latency: one cycle from an in_valid/in_ready handshake to out_valid.
- Throughput: one word per cycle with out_ready held at 1.
- Simultaneous events:
  - A FULL register draining (out_ready=1) while a new grant occurs is replaced in the same edge, with no bubble.
  - If out_ready=1 and there is no request, the state goes FULL->EMPTY.
- Fairness: with all 8 channels continuously valid and out_ready=1, grants cycle 0,1,...,7,0,...
  - Each channel waits at most 7 grants.
- Inputs are sampled only when granted; in_data of non-granted channels is ignored.

Decomposition:
- Shared package mux_pkg:
  - WIDTH=16, NCH=8, SEL_W=3 constants.
  - State encoding ST_EMPTY=1'b0, ST_FULL=1'b1.
- Sub-module rr_arbiter8:
  - Combinational.
  - Inputs: req[7:0], ptr[2:0], en.
  - Outputs: gnt[7:0] one-hot, gnt_idx[2:0], any.
- Top level owns the ptr register, the state register and the output register.
- Data selection inside the top level reuses the existing Mux8Way16 from the codebase, indexed by gnt_idx.

Test Plan:
- Reset check: rst_n=0 for 2 cycles with in_valid=8'hFF.
  - Required: out_valid=0, out_data=0, out_sel=0, in_ready=0 throughout.
  - Required: first grant after release goes to channel 0.
- Single channel: in_valid=8'b0010_0000, ch5 data=16'hBEEF, out_ready=1.
  - Required: in_ready=8'b0010_0000.
  - Required next cycle: out_valid=1, out_data=16'hBEEF, out_sel=5.
- Round-robin wrap: in_valid=8'hFF, channel i data=16'h1000+i, out_ready=1 for 10 cycles.
  - Required out_sel sequence: 0,1,2,3,4,5,6,7,0,1.
  - Required: out_data matches out_sel.
- Backpressure: FULL with out_sel=2, out_data=16'h1002; out_ready=0 for 3 cycles while in_valid=8'hFF.
  - Required: in_ready=0, outputs stable.
  - Required: on out_ready=1, next word is from channel 3.
- Sparse wrap: ptr=6 (last grant 5), in_valid=8'b0000_0011.
  - Required: grant channel 0, then channel 1, then out_valid drops to 0 when in_valid=0.
- Mid-operation reset: in FULL with out_valid=1, assert rst_n=0 for 1 cycle.
  - Required next cycle: out_valid=0, ptr=0.
  - Required: no in_ready pulse during reset.
